// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {bout, diff} = a - b - bin over WIDTH bits,
// one full-subtractor cell plus a borrow flop, sequenced by start/busy/done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // state   | meaning
    // S_IDLE  | waiting for start; diff/bout hold last result
    // S_SHIFT | one bit per cycle through the full-subtractor cell
    // S_DONE  | publish result and pulse done on the following cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic d_bit;
    logic borrow_nx;

    assign d_bit     = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
    assign borrow_nx = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_q      <= r_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_d      = r_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // result enters at the MSB so bit 0 lands in r[0] after WIDTH shifts
                r_d      = {d_bit, r_q[WIDTH-1:1]};
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                diff_d  = r_q;
                bout_d  = borrow_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance for functional/timing
// scenarios, WIDTH=4 instance for the full operand sweep.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;

    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start4, bin4;
    logic [3:0] a4, b4;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    int n_cmp;
    int n_err;
    int overlap;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((busy8 && done8) || (busy4 && done4)) overlap++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one WIDTH=8 op and returns the values seen on the done cycle.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                           output logic [7:0] d, output logic bo, output logic timed_out);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        step();
        start8 = 1'b0;
        timed_out = 1'b1;
        d = 'x; bo = 1'bx;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin
                d = diff8; bo = bout8; timed_out = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        n_cmp += 4;
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done8); end
        if (diff8 !== 8'h00) begin n_err++; $display("FAIL reset_diff: got %h expected 00", diff8); end
        if (bout8 !== 1'b0) begin n_err++; $display("FAIL reset_bout: got %b expected 0", bout8); end
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hFF};
        logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'h00};
        logic       vi [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed [4] = '{8'h02, 8'hFE, 8'hFF, 8'hFE};
        logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] d;
        logic bo, to;
        for (int i = 0; i < 4; i++) begin
            run_op8(va[i], vb[i], vi[i], d, bo, to);
            n_cmp += 3;
            if (to !== 1'b0) begin n_err++; $display("FAIL basic%0d_timeout: no done seen", i); end
            if (d !== ed[i]) begin n_err++; $display("FAIL basic%0d_diff: got %h expected %h", i, d, ed[i]); end
            if (bo !== eb[i]) begin n_err++; $display("FAIL basic%0d_bout: got %b expected %b", i, bo, eb[i]); end
            step();
        end
    endtask

    task automatic test_reset_midop();
        int done_seen;
        // leave a nonzero result held so the reset clear is observable
        logic [7:0] d;
        logic bo, to;
        run_op8(8'h05, 8'h03, 1'b0, d, bo, to);
        step();
        a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (busy8 !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy: got %b expected 1", busy8); end
        rst_n = 1'b0;
        #2;
        n_cmp += 4;
        if (busy8 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
        if (done8 !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", done8); end
        if (diff8 !== 8'h00) begin n_err++; $display("FAIL midrst_diff: got %h expected 00", diff8); end
        if (bout8 !== 1'b0) begin n_err++; $display("FAIL midrst_bout: got %b expected 0", bout8); end
        step();
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done8 || busy8) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", done_seen); end
    endtask

    task automatic test_timing();
        int busy_cnt, done_cnt, done_k;
        int ov0;
        ov0 = overlap;
        busy_cnt = 0; done_cnt = 0; done_k = -1;
        a8 = 8'h5A; b8 = 8'h33; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (busy8) busy_cnt++;
            if (done8) begin done_cnt++; done_k = k; end
            step();
        end
        n_cmp += 5;
        if (busy_cnt !== 8) begin n_err++; $display("FAIL timing_busy_cycles: got %0d expected 8", busy_cnt); end
        if (done_cnt !== 1) begin n_err++; $display("FAIL timing_done_cycles: got %0d expected 1", done_cnt); end
        if (done_k !== 9) begin n_err++; $display("FAIL timing_done_edge: got N+%0d expected N+9", done_k); end
        if (overlap !== ov0) begin n_err++; $display("FAIL timing_overlap: got %0d expected %0d", overlap, ov0); end
        if (diff8 !== 8'h27) begin n_err++; $display("FAIL timing_diff: got %h expected 27", diff8); end
    endtask

    task automatic test_ignored();
        int done_cnt, busy_after;
        logic [7:0] d;
        logic bo, to;
        done_cnt = 0; busy_after = 0;
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1;
        for (int k = 0; k < 22; k++) begin
            start8 = (k == 3) || (k == 8);
            if (done8) done_cnt++;
            if (k > 9 && busy8) busy_after++;
            if (k == 9) begin d = diff8; bo = bout8; end
            step();
        end
        start8 = 1'b0;
        n_cmp += 4;
        if (done_cnt !== 1) begin n_err++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt); end
        if (busy_after !== 0) begin n_err++; $display("FAIL ignored_restart: got %0d busy cycles expected 0", busy_after); end
        if (d !== 8'h02) begin n_err++; $display("FAIL ignored_diff: got %h expected 02", d); end
        if (bo !== 1'b0) begin n_err++; $display("FAIL ignored_bout: got %b expected 0", bo); end

        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'hAA; b8 = 8'hAA; bin8 = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin d = diff8; bo = bout8; to = 1'b0; break; end
            step();
        end
        n_cmp += 3;
        if (to !== 1'b0) begin n_err++; $display("FAIL stable_timeout: no done seen"); end
        if (d !== 8'h7F) begin n_err++; $display("FAIL stable_diff: got %h expected 7F", d); end
        if (bo !== 1'b0) begin n_err++; $display("FAIL stable_bout: got %b expected 0", bo); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] na [3] = '{8'h10, 8'h01, 8'hAA};
        logic [7:0] nb [3] = '{8'h01, 8'h10, 8'h55};
        logic [7:0] ed [3] = '{8'h0F, 8'hF1, 8'h55};
        logic       eb [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] gd [3];
        logic       gb [3];
        int         dk [3];
        int ndone;
        ndone = 0;
        for (int i = 0; i < 3; i++) begin gd[i] = 'x; gb[i] = 1'bx; dk[i] = -100; end
        a8 = na[0]; b8 = nb[0]; bin8 = 1'b0; start8 = 1'b1;
        step();
        for (int k = 0; k < 45; k++) begin
            if (done8) begin
                if (ndone < 3) begin gd[ndone] = diff8; gb[ndone] = bout8; dk[ndone] = k; end
                ndone++;
                if (ndone < 3) begin a8 = na[ndone]; b8 = nb[ndone]; end
            end
            if (ndone == 2 && busy8) start8 = 1'b0;
            step();
        end
        start8 = 1'b0;
        n_cmp += 9;
        if (ndone !== 3) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 3", ndone); end
        for (int i = 0; i < 3; i++) begin
            if (gd[i] !== ed[i]) begin n_err++; $display("FAIL b2b%0d_diff: got %h expected %h", i, gd[i], ed[i]); end
            if (gb[i] !== eb[i]) begin n_err++; $display("FAIL b2b%0d_bout: got %b expected %b", i, gb[i], eb[i]); end
        end
        // IDLE cycle between DONE and the next accepted start gives a 10-cycle period
        if (dk[1] - dk[0] !== 10) begin n_err++; $display("FAIL b2b_spacing01: got %0d expected 10", dk[1] - dk[0]); end
        if (dk[2] - dk[1] !== 10) begin n_err++; $display("FAIL b2b_spacing12: got %0d expected 10", dk[2] - dk[1]); end
    endtask

    task automatic test_sweep4();
        logic [4:0] exp5, got5;
        logic to;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    to = 1'b1;
                    got5 = 'x;
                    for (int k = 0; k < 12; k++) begin
                        if (done4) begin got5 = {bout4, diff4}; to = 1'b0; break; end
                        step();
                    end
                    exp5 = 5'((ai - bi - ci) & 31);
                    n_cmp++;
                    if (to !== 1'b0 || got5 !== exp5) begin
                        n_err++;
                        $display("FAIL sweep4 a=%0d b=%0d bin=%0d: got %b expected %b", ai, bi, ci, got5, exp5);
                    end
                end
            end
        end
        n_cmp++;
        if (overlap !== 0) begin n_err++; $display("FAIL busy_done_overlap: got %0d expected 0", overlap); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; overlap = 0;
        rst_n = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_reset_midop();
        test_timing();
        test_ignored();
        test_back_to_back();
        test_sweep4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
